// File: rtl/ram_controller.sv
// ----------------------------------------------------------------------------
// ram_controller
//
// Request-side sequencer for the select-strobed RAM. The RAM samples its
// address/operation/wdata on the rising edge of `select`. Requests arrive over
// a valid/ready handshake and are buffered in a small FIFO. Each request is
// then played out as setup -> strobe -> (capture) -> release. Read data returns
// over a valid/ready response channel.
//
// Optional feature (macro RAM_CTRL_BOUNDS_CHECK_EN):
//   When defined, a popped request whose address is >= WORD_AMOUNT never
//   reaches the RAM. A read answers with rsp_error=1 and rsp_rdata=0. A write
//   is dropped and sets the sticky err_seen_r bit. When undefined, addresses
//   go to the RAM unchecked and rsp_error is tied to 0.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (req_ready = !fifo_full)
//   req_write/req_addr/req_wdata    request payload (1 = write)
//   rsp_valid/rsp_ready             read-response handshake
//   rsp_rdata/rsp_error             response payload
//   mem_address/mem_select          RAM address / access strobe
//   mem_operation/mem_wdata         RAM op (1 = WRITE) / write data
//   mem_rdata                       RAM read data
//   busy                            FSM active or FIFO non-empty
// ----------------------------------------------------------------------------
module ram_controller #(
    parameter  int WORD_SIZE   = 20,
    parameter  int WORD_AMOUNT = 30,
    parameter  int FIFO_DEPTH  = 4,
    localparam int ADDR_W      = $clog2(WORD_AMOUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_error,
    output logic [ADDR_W-1:0]    mem_address,
    output logic                 mem_select,
    output logic                 mem_operation,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 1 + ADDR_W + WORD_SIZE;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // FIFO: pointers carry one extra bit so full and empty can be told apart
    logic [ENTRY_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_r;
    logic [PTR_W:0]       rd_ptr_r;
    logic [PTR_W:0]       wr_ptr_nxt_s;
    logic [PTR_W:0]       rd_ptr_nxt_s;
    logic                 empty_s;
    logic                 full_nxt_s;
    logic                 push_s;
    logic                 pop_s;
    logic [ENTRY_W-1:0]   head_s;
    logic                 head_write_s;
    logic [ADDR_W-1:0]    head_addr_s;
    logic [WORD_SIZE-1:0] head_wdata_s;
    logic                 head_bad_s;

    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;

    logic                 req_ready_r;
    logic                 busy_r;
    logic                 rsp_valid_r;
    logic [WORD_SIZE-1:0] rsp_rdata_r;
    logic [ADDR_W-1:0]    mem_address_r;
    logic                 mem_select_r;
    logic                 mem_operation_r;
    logic [WORD_SIZE-1:0] mem_wdata_r;

    assign push_s       = req_valid && req_ready_r;
    // A held, unaccepted response blocks every pop so order is preserved
    assign pop_s        = (state_r == ST_IDLE) && !empty_s && !(rsp_valid_r && !rsp_ready);
    assign empty_s      = (wr_ptr_r == rd_ptr_r);
    assign wr_ptr_nxt_s = push_s ? (wr_ptr_r + (PTR_W+1)'(1)) : wr_ptr_r;
    assign rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + (PTR_W+1)'(1)) : rd_ptr_r;
    assign full_nxt_s   = (wr_ptr_nxt_s[PTR_W] != rd_ptr_nxt_s[PTR_W]) &&
                          (wr_ptr_nxt_s[PTR_W-1:0] == rd_ptr_nxt_s[PTR_W-1:0]);

    assign head_s       = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
    assign head_write_s = head_s[ENTRY_W-1];
    assign head_addr_s  = head_s[ENTRY_W-2 -: ADDR_W];
    assign head_wdata_s = head_s[WORD_SIZE-1:0];

`ifdef RAM_CTRL_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] WORD_LIMIT = (ADDR_W+1)'(WORD_AMOUNT);

    logic                 bad_r;
    logic                 bad_write_r;
    logic                 rsp_error_r;
    logic                 err_seen_r;

    assign head_bad_s = ({1'b0, head_addr_s} >= WORD_LIMIT);
    assign rsp_error  = rsp_error_r;
`else
    assign head_bad_s = 1'b0;
    assign rsp_error  = 1'b0;
`endif

    assign req_ready     = req_ready_r;
    assign busy          = busy_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign mem_address   = mem_address_r;
    assign mem_select    = mem_select_r;
    assign mem_operation = mem_operation_r;
    assign mem_wdata     = mem_wdata_r;

    // Next-state logic for the access sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    // Out-of-range requests jump straight to release: no strobe
                    state_nxt_s = head_bad_s ? ST_RELEASE : ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP:   state_nxt_s = ST_STROBE;
            ST_STROBE:  state_nxt_s = mem_operation_r ? ST_RELEASE : ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_RELEASE;
            ST_RELEASE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FIFO storage write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= {req_write, req_addr, req_wdata};
        end
    end

    // FIFO pointers, FSM state and the registered ready/busy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            state_r     <= state_nxt_s;
            req_ready_r <= !full_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE) || (wr_ptr_nxt_s != rd_ptr_nxt_s);
        end
    end

    // RAM bus: payload latched at pop and held to release; select tracks strobe/capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_address_r   <= '0;
            mem_operation_r <= 1'b0;
            mem_wdata_r     <= '0;
            mem_select_r    <= 1'b0;
        end else begin
            if (pop_s && !head_bad_s) begin
                mem_address_r   <= head_addr_s;
                mem_operation_r <= head_write_s;
                mem_wdata_r     <= head_wdata_s;
            end
            mem_select_r <= (state_nxt_s == ST_STROBE) || (state_nxt_s == ST_CAPTURE);
        end
    end

`ifdef RAM_CTRL_BOUNDS_CHECK_EN
    // Out-of-range bookkeeping: remember the rejected command and the sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_r       <= 1'b0;
            bad_write_r <= 1'b0;
            err_seen_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                bad_r       <= head_bad_s;
                bad_write_r <= head_write_s;
            end else if (state_r == ST_RELEASE) begin
                bad_r <= 1'b0;
            end
            if ((state_r == ST_RELEASE) && bad_r && bad_write_r) begin
                err_seen_r <= 1'b1;
            end
        end
    end
`endif

    // Response register: loaded at capture (or error), cleared on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
            rsp_error_r <= 1'b0;
`endif
        end else if (state_r == ST_CAPTURE) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= mem_rdata;
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
            rsp_error_r <= 1'b0;
        end else if ((state_r == ST_RELEASE) && bad_r && !bad_write_r) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= '0;
            rsp_error_r <= 1'b1;
`endif
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
            rsp_error_r <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ram_controller.sv
// ----------------------------------------------------------------------------
// tb_ram_controller
//
// Directed bench for ram_controller. It contains a behavioural model of the
// select-strobed RAM: an access happens on each rising edge of mem_select. The
// model keeps a log of write addresses so the bench can check ordering.
// Inputs are driven and outputs sampled 1 time unit after the rising clock edge.
// ----------------------------------------------------------------------------
module tb_ram_controller;

    localparam int WS = 20;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [WS-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [WS-1:0] rsp_rdata;
    logic          rsp_error;
    logic [AW-1:0] mem_address;
    logic          mem_select;
    logic          mem_operation;
    logic [WS-1:0] mem_wdata;
    logic [WS-1:0] ram_rdata;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sel_rises = 0;
    logic [WS-1:0] ram [32];
    int wlog [$];

    ram_controller #(.WORD_SIZE(20), .WORD_AMOUNT(30), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .mem_address(mem_address), .mem_select(mem_select),
        .mem_operation(mem_operation), .mem_wdata(mem_wdata),
        .mem_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: access on the rising edge of select
    always @(posedge mem_select) begin
        sel_rises = sel_rises + 1;
        if (mem_operation) begin
            ram[mem_address] = mem_wdata;
            wlog.push_back(int'(mem_address));
        end else begin
            ram_rdata = ram[mem_address];
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [WS-1:0] d,
                        output int acc);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            if (req_ready === 1'b1) begin
                @(posedge clk); #1;
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        checks++;
        if (acc < 0) begin
            failures++;
            $display("FAIL send_accept addr=%0d got=timeout expected=accepted", a);
        end
    endtask

    task automatic wait_rsp(output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin
                c = cyc;
                break;
            end
        end
        checks++;
        if (c < 0) begin
            failures++;
            $display("FAIL wait_rsp got=timeout expected=rsp_valid");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_idle got=busy expected=idle");
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_error, mem_select, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=00000",
                     {req_ready, rsp_valid, rsp_error, mem_select, busy});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got=%b expected=0", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_edge got=%b%b expected=10", req_ready, busy);
        end
    endtask

    task automatic test_write_read();
        int rs, a, c;
        rs = sel_rises;
        send(1'b1, 5'd5, 20'hABCDE, a);
        @(posedge clk); #1;
        checks++;
        if (mem_select !== 1'b0) begin
            failures++;
            $display("FAIL setup_select got=%b expected=0", mem_select);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_select !== 1'b1 || mem_address !== 5'd5 || mem_operation !== 1'b1) begin
            failures++;
            $display("FAIL strobe_bus got=%b/%0d/%b expected=1/5/1",
                     mem_select, mem_address, mem_operation);
        end
        wait_idle();
        checks++;
        if (sel_rises - rs != 1 || ram[5] !== 20'hABCDE) begin
            failures++;
            $display("FAIL write5 got=%0d/%h expected=1/abcde", sel_rises - rs, ram[5]);
        end
        send(1'b0, 5'd5, 20'h00000, a);
        wait_rsp(c);
        checks++;
        if (c - a != 4) begin
            failures++;
            $display("FAIL read_latency got=%0d expected=4", c - a);
        end
        checks++;
        if (rsp_rdata !== 20'hABCDE || rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL read5_data got=%h/%b expected=abcde/0", rsp_rdata, rsp_error);
        end
        checks++;
        if (sel_rises - rs != 2) begin
            failures++;
            $display("FAIL read5_rises got=%0d expected=2", sel_rises - rs);
        end
        wait_idle();
    endtask

    task automatic test_fifo_full();
        int rs, a, c, wl;
        rsp_ready = 1'b0;
        send(1'b0, 5'd10, 20'h00000, a);
        wait_rsp(c);
        rs = sel_rises;
        wl = wlog.size();
        for (int k = 0; k < 4; k++) begin
            send(1'b1, AW'(k), WS'(k + 1), a);
        end
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || sel_rises != rs) begin
            failures++;
            $display("FAIL fifo_full got=%b/%b/%0d expected=0/1/0",
                     req_ready, rsp_valid, sel_rises - rs);
        end
        rsp_ready = 1'b1;
        send(1'b1, 5'd4, 20'h00005, a);
        wait_idle();
        checks++;
        if (wlog.size() - wl != 5) begin
            failures++;
            $display("FAIL fifo_count got=%0d expected=5", wlog.size() - wl);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (wlog.size() - wl != 5 || wlog[wl + k] != k || ram[k] !== WS'(k + 1)) begin
                failures++;
                $display("FAIL fifo_order idx=%0d got=%h expected=%h", k, ram[k], k + 1);
            end
        end
    endtask

    task automatic test_rsp_hold();
        int rs, a, c;
        rsp_ready = 1'b0;
        rs = sel_rises;
        send(1'b0, 5'd1, 20'h00000, a);
        send(1'b0, 5'd2, 20'h00000, a);
        wait_rsp(c);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 20'h00002) begin
            failures++;
            $display("FAIL hold_first got=%b/%h expected=1/00002", rsp_valid, rsp_rdata);
        end
        checks++;
        if (mem_select !== 1'b0 || sel_rises - rs != 1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_stall got=%b/%0d/%b expected=0/1/1",
                     mem_select, sel_rises - rs, busy);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_clear got=%b expected=0", rsp_valid);
        end
        wait_rsp(c);
        checks++;
        if (rsp_rdata !== 20'h00003 || sel_rises - rs != 2) begin
            failures++;
            $display("FAIL hold_second got=%h/%0d expected=00003/2", rsp_rdata, sel_rises - rs);
        end
        wait_idle();
    endtask

    task automatic test_boundary();
        int a, c;
        send(1'b1, 5'd29, 20'h12345, a);
        wait_idle();
        checks++;
        if (wlog[wlog.size() - 1] != 29 || ram[29] !== 20'h12345 || ram[0] !== 20'h00001) begin
            failures++;
            $display("FAIL top_write got=%0d/%h expected=29/12345", wlog[wlog.size() - 1], ram[29]);
        end
        send(1'b0, 5'd29, 20'h00000, a);
        wait_rsp(c);
        checks++;
        if (rsp_rdata !== 20'h12345) begin
            failures++;
            $display("FAIL top_read got=%h expected=12345", rsp_rdata);
        end
        wait_idle();
    endtask

    task automatic test_bounds();
        int rs, a, c;
        rs = sel_rises;
        send(1'b0, 5'd31, 20'h00000, a);
        wait_rsp(c);
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
        checks++;
        if (rsp_error !== 1'b1 || rsp_rdata !== 20'h00000 || sel_rises != rs || c - a != 2) begin
            failures++;
            $display("FAIL bounds_read got=%b/%h/%0d/%0d expected=1/00000/0/2",
                     rsp_error, rsp_rdata, sel_rises - rs, c - a);
        end
        wait_idle();
        send(1'b1, 5'd31, 20'h11111, a);
        wait_idle();
        checks++;
        if (sel_rises != rs || rsp_valid !== 1'b0 || ram[31] !== 20'h5A5A5) begin
            failures++;
            $display("FAIL bounds_write got=%0d/%b/%h expected=0/0/5a5a5",
                     sel_rises - rs, rsp_valid, ram[31]);
        end
`else
        checks++;
        if (rsp_error !== 1'b0 || rsp_rdata !== 20'h5A5A5 || sel_rises - rs != 1 || c - a != 4) begin
            failures++;
            $display("FAIL unchecked_read got=%b/%h/%0d/%0d expected=0/5a5a5/1/4",
                     rsp_error, rsp_rdata, sel_rises - rs, c - a);
        end
`endif
        wait_idle();
    endtask

    task automatic test_reset_mid_op();
        int rs, a, wl;
        bit seen, hit3;
        rs = sel_rises;
        wl = wlog.size();
        send(1'b1, 5'd7, 20'h77777, a);
        send(1'b1, 5'd3, 20'h33333, a);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_select === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midop_strobe got=timeout expected=select");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_select, busy, req_ready, rsp_valid} !== 4'b0) begin
            failures++;
            $display("FAIL midop_reset got=%b expected=0000",
                     {mem_select, busy, req_ready, rsp_valid});
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midop_empty got=%b%b expected=01", busy, req_ready);
        end
        hit3 = 1'b0;
        for (int k = wl; k < wlog.size(); k++) begin
            if (wlog[k] == 3) hit3 = 1'b1;
        end
        checks++;
        if (hit3 || ram[3] !== 20'h00004 || sel_rises - rs != 1) begin
            failures++;
            $display("FAIL midop_discard got=%h/%0d expected=00004/1", ram[3], sel_rises - rs);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        ram_rdata = '0;
        for (int i = 0; i < 32; i++) ram[i] = '0;
        ram[31] = 20'h5A5A5;

        test_reset();
        test_write_read();
        test_fifo_full();
        test_rsp_hold();
        test_boundary();
        test_bounds();
        test_reset_mid_op();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_controller.md
Name: ram_controller

Overview:
- Request-side sequencer that sits directly upstream of the team's select-strobed RAM, which samples on the rising edge of `select`.
- Accepts read/write requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the RAM's address/select/operation/wdata with a setup-strobe-release sequence.
- Returns read data over a valid/ready response channel.

Parameters:
- WORD_SIZE, 20, data width in bits; must match the RAM's word_size.
- WORD_AMOUNT, 30, number of RAM words; address width ADDR_W = $clog2(WORD_AMOUNT).
- FIFO_DEPTH, 4, request FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; equals !fifo_full.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target word.
- req_wdata  in  WORD_SIZE  write data; ignored on reads.
- rsp_valid  out  1  read response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  WORD_SIZE  read data.
- rsp_error  out  1  response is an error; see Optional Feature.
- mem_address  out  ADDR_W  to RAM address.
- mem_select  out  1  to RAM select; rising edge triggers the access.
- mem_operation  out  1  to RAM operation; 0 = READ, 1 = WRITE.
- mem_wdata  out  WORD_SIZE  to RAM wdata.
- mem_rdata  in  WORD_SIZE  from RAM rdata.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- **Clock and reset.** One clock; reset is asynchronous and active-low.
  - While rst_n=0, every output is 0: req_ready=0, rsp_valid=0, rsp_error=0, mem_select=0, busy=0. The FIFO is flushed and the FSM is forced to IDLE.
  - req_ready rises on the first clk edge after rst_n deasserts.
- **Request FIFO.**
  - A push happens on an edge where req_valid && req_ready.
  - Full: req_ready=0. There is no same-cycle pop/push bypass, so a full FIFO stays not-ready for that cycle.
  - Pointers wrap modulo FIFO_DEPTH. An extra occupancy bit distinguishes full from empty.
- **FSM states:** IDLE, SETUP, STROBE, CAPTURE, RELEASE.
  - IDLE: if the FIFO is non-empty, pop the head into the command register and go to SETUP.
    - A read is not popped while rsp_valid && !rsp_ready. In that case the FSM stalls in IDLE. Writes are also stalled, to preserve order.
  - SETUP: mem_address, mem_operation and mem_wdata are driven from the command register, with mem_select=0. Go to STROBE.
  - STROBE: mem_select=1, so the RAM performs the access at the rising edge. Reads go to CAPTURE; writes go to RELEASE.
  - CAPTURE: mem_select stays 1. At the edge, register mem_rdata into rsp_rdata, set rsp_valid=1, then go to RELEASE.
  - RELEASE: mem_select=0. Go to IDLE.
- **Bus stability.** mem_address, mem_operation and mem_wdata are held stable from SETUP through RELEASE.
- **Latency**, counting from request acceptance at edge N into an empty, idle block:
  - mem_select rises after edge N+2.
  - For a read, rsp_valid=1 after edge N+4.
  - For a write, busy falls after edge N+4 if no further requests are pending.
  - Throughput: 1 read per 5 cycles, 1 write per 4 cycles.
- **Response channel.**
  - rsp_valid, rsp_rdata and rsp_error hold until an edge where rsp_ready=1; rsp_valid then clears.
  - Writes produce no response.
- **Ordering.** Accesses execute strictly in FIFO order. A read after a write to the same address returns the new data.
- **Reset mid-operation.** mem_select drops to 0 immediately. This falling edge causes no RAM access. Pending requests are discarded and any held response is lost.

Optional Feature:
- Macro: RAM_CTRL_BOUNDS_CHECK_EN.
- Defined:
  - A popped request with addr >= WORD_AMOUNT skips SETUP, STROBE and CAPTURE. mem_select never rises for it.
  - A read in this case returns rsp_valid=1 with rsp_error=1 and rsp_rdata=0, one edge after the pop.
  - A write in this case is dropped, and sticky bit err_seen is set; err_seen is cleared only by reset.
  - busy stays asserted for that cycle.
- Undefined:
  - The address is passed to the RAM unchecked.
  - rsp_error is tied to 0.

Test Plan:
- Write 0xABCDE to addr 5, then read addr 5 → exactly one mem_select rise per op. rsp_rdata=0xABCDE, rsp_valid rises 4 edges after read acceptance.
- Push 5 writes back-to-back with FIFO_DEPTH=4 and FSM stalled → req_ready=0 after the 4th accept. All 5 eventually land in order: addrs 0..4 hold data 1..5.
- Two reads (addr 1, addr 2) with rsp_ready=0 → the first response is held stable and the second read is not issued (mem_select stays 0). Raise rsp_ready → the second response follows with the correct data.
- Assert rst_n=0 during STROBE of a queued write → mem_select=0 at once, the FIFO is empty, and the remaining queued write to addr 3 never reaches the RAM.
- Read and write at addr WORD_AMOUNT-1=29 → correct data; no address wrap.
- With RAM_CTRL_BOUNDS_CHECK_EN, read addr 31 → rsp_error=1, rsp_rdata=0, no mem_select pulse. Without the macro, the access is issued.
